// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: shared op encodings and FSM states for the burst shift register
package shift_reg_pkg;
    typedef enum logic [2:0] {
        OP_HOLD = 3'b000,
        OP_SHL  = 3'b001,
        OP_SHR  = 3'b010,
        OP_ROL  = 3'b011,
        OP_ROR  = 3'b100,
        OP_ASR  = 3'b101
    } op_e;
    typedef enum logic {IDLE, RUN} state_e;
endpackage

// File: rtl/shift_unit.sv
// shift_unit: combinational next-value and leaving-bit for one shift step
module shift_unit
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] value,
    input  logic [2:0]       op,
    input  logic             serialIn,
    output logic [WIDTH-1:0] next_value,
    output logic             serialOut
);
    assign next_value = op == OP_SHL ? {value[WIDTH-2:0], serialIn} :
                        op == OP_SHR ? {serialIn, value[WIDTH-1:1]} :
                        op == OP_ROL ? {value[WIDTH-2:0], value[WIDTH-1]} :
                        op == OP_ROR ? {value[0], value[WIDTH-1:1]} :
                        op == OP_ASR ? {value[WIDTH-1], value[WIDTH-1:1]} : value;
    assign serialOut = (op == OP_SHL || op == OP_ROL) ? value[WIDTH-1] :
                       (op == OP_SHR || op == OP_ROR || op == OP_ASR) ? value[0] : 1'b0;
endmodule

// File: rtl/shift_reg_burst.sv
// shift_reg_burst: shift register with single-step ops and counted shift bursts
module shift_reg_burst
    import shift_reg_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [CNT_W-1:0] shamt,
    input  logic [WIDTH-1:0] parallelIn,
    input  logic             serialIn,
    output logic             serialOut,
    output logic [WIDTH-1:0] parallelOut,
    output logic             busy,
    output logic             done
);
    state_e           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [2:0]       op_q, op_nx, op_eff;
    logic [WIDTH-1:0] data, data_nx, shifted;
    logic             done_nx;

    assign busy        = state == RUN;
    assign op_eff      = busy ? op_q : op;
    assign parallelOut = data;

    shift_unit #(.WIDTH(WIDTH)) u_shift (
        .value      (data),
        .op         (op_eff),
        .serialIn   (serialIn),
        .next_value (shifted),
        .serialOut  (serialOut)
    );

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        op_nx    = op_q;
        data_nx  = data;
        done_nx  = 1'b0;
        if (en) begin
            if (state == IDLE) begin
                if (load) begin
                    data_nx = parallelIn;
                end else if (start) begin
                    // a zero-length burst completes at once without entering RUN
                    if (shamt == '0) begin
                        done_nx = 1'b1;
                    end else begin
                        state_nx = RUN;
                        op_nx    = op;
                        cnt_nx   = shamt > CNT_W'(WIDTH) ? CNT_W'(WIDTH) : shamt;
                    end
                end else begin
                    data_nx = shifted;
                end
            end else begin
                data_nx = shifted;
                cnt_nx  = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            op_q  <= OP_HOLD;
            data  <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            op_q  <= op_nx;
            data  <= data_nx;
            done  <= done_nx;
        end
    end
endmodule

// File: tb/tb_shift_reg_burst.sv
// tb_shift_reg_burst: table-driven plus hand-written sequences for shift_reg_burst
module tb_shift_reg_burst;
    import shift_reg_pkg::*;
    localparam int WIDTH = 8;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk = 1'b0, rst = 1'b0, en = 1'b0, load = 1'b0, start = 1'b0, serialIn = 1'b0;
    logic [2:0]       op = 3'b000;
    logic [CNT_W-1:0] shamt = '0;
    logic [WIDTH-1:0] parallelIn = '0;
    logic             serialOut, busy, done;
    logic [WIDTH-1:0] parallelOut;
    int               checks = 0, errors = 0;

    shift_reg_burst #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .load        (load),
        .start       (start),
        .op          (op),
        .shamt       (shamt),
        .parallelIn  (parallelIn),
        .serialIn    (serialIn),
        .serialOut   (serialOut),
        .parallelOut (parallelOut),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             en, load, start;
        logic [2:0]       op;
        logic [CNT_W-1:0] shamt;
        logic [7:0]       pin;
        logic             sin;
        logic [7:0]       q;
        logic             busy, done, sout;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic e, l, s, input logic [2:0] o, input logic [CNT_W-1:0] sh,
                       input logic [7:0] p, input logic si, input logic [7:0] q,
                       input logic b, d, so);
        vec_t v;
        v.en = e; v.load = l; v.start = s; v.op = o; v.shamt = sh; v.pin = p; v.sin = si;
        v.q = q; v.busy = b; v.done = d; v.sout = so;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [7:0] q, input logic b, d, so);
        check({tag, " q"}, 32'(parallelOut), 32'(q));
        check({tag, " busy"}, 32'(busy), 32'(b));
        check({tag, " done"}, 32'(done), 32'(d));
        check({tag, " sout"}, 32'(serialOut), 32'(so));
    endtask

    task automatic drive(input logic e, l, s, input logic [2:0] o, input logic [CNT_W-1:0] sh,
                         input logic [7:0] p, input logic si);
        en = e; load = l; start = s; op = o; shamt = sh; parallelIn = p; serialIn = si;
    endtask

    initial begin
        logic [7:0] e;
        int busy_cnt;
        // en, load, start, op, shamt, pin, sin | q, busy, done, sout
        add(1, 0, 0, OP_SHR,  0, 8'h00, 1, 8'h80, 0, 0, 0);
        add(1, 0, 0, OP_SHR,  0, 8'h00, 1, 8'hC0, 0, 0, 0);
        add(1, 0, 0, OP_SHR,  0, 8'h00, 1, 8'hE0, 0, 0, 0);
        add(1, 0, 0, OP_SHR,  0, 8'h00, 1, 8'hF0, 0, 0, 0);
        add(1, 0, 0, 3'b110,  0, 8'h00, 1, 8'hF0, 0, 0, 0);
        add(0, 0, 0, OP_SHL,  0, 8'h00, 1, 8'hF0, 0, 0, 1);
        add(1, 0, 0, OP_ROR,  0, 8'h00, 0, 8'h78, 0, 0, 0);
        add(1, 0, 1, OP_ROL,  0, 8'h00, 0, 8'h78, 0, 1, 0);
        add(1, 0, 0, OP_HOLD, 0, 8'h00, 0, 8'h78, 0, 0, 0);
        add(1, 1, 1, OP_ROL,  3, 8'hA5, 0, 8'hA5, 0, 0, 1);
        add(1, 0, 1, OP_ROL,  3, 8'h00, 0, 8'hA5, 1, 0, 1);
        add(1, 0, 0, OP_HOLD, 0, 8'h00, 0, 8'h4B, 1, 0, 0);
        add(1, 0, 0, OP_HOLD, 0, 8'h00, 0, 8'h96, 1, 0, 1);
        add(1, 0, 0, OP_HOLD, 0, 8'h00, 0, 8'h2D, 0, 1, 0);
        add(1, 0, 0, OP_HOLD, 0, 8'h00, 0, 8'h2D, 0, 0, 0);
        add(1, 1, 0, OP_HOLD, 0, 8'h90, 0, 8'h90, 0, 0, 0);
        add(1, 0, 1, OP_ASR,  2, 8'h00, 0, 8'h90, 1, 0, 0);
        add(1, 0, 0, OP_HOLD, 0, 8'h00, 0, 8'hC8, 1, 0, 0);
        add(1, 0, 0, OP_HOLD, 0, 8'h00, 0, 8'hE4, 0, 1, 0);

        // reset state, including an edge with load requested while held in reset
        #1;
        check_all("reset", 8'h00, 0, 0, 0);
        drive(1, 1, 0, OP_ROL, 0, 8'hFF, 1);
        tick();
        check_all("reset_edge", 8'h00, 0, 0, 0);
        drive(1, 0, 0, OP_HOLD, 0, 8'h00, 0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].load, vecs[i].start, vecs[i].op, vecs[i].shamt,
                  vecs[i].pin, vecs[i].sin);
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].q, vecs[i].busy, vecs[i].done, vecs[i].sout);
        end

        // clamped burst: shamt 12 runs exactly WIDTH shifts
        drive(1, 1, 0, OP_HOLD, 0, 8'hFF, 0);
        tick();
        check_all("clamp_load", 8'hFF, 0, 0, 0);
        drive(1, 0, 1, OP_SHL, 12, 8'h00, 0);
        tick();
        check_all("clamp_start", 8'hFF, 1, 0, 1);
        busy_cnt = 1;
        drive(1, 0, 0, OP_HOLD, 0, 8'h00, 0);
        for (int i = 1; i <= 8; i++) begin
            tick();
            e = 8'hFF << i;
            check_all($sformatf("clamp_e%0d", i), e, i < 8, i == 8, i < 8);
            if (busy) busy_cnt++;
        end
        check("clamp_busy_cycles", 32'(busy_cnt), 32'd8);

        // stall mid-burst with load/start/op noise during RUN
        drive(1, 1, 0, OP_HOLD, 0, 8'h81, 0);
        tick();
        check_all("stall_load", 8'h81, 0, 0, 0);
        drive(1, 0, 1, OP_ROR, 3, 8'h00, 0);
        tick();
        check_all("stall_start", 8'h81, 1, 0, 1);
        drive(1, 0, 0, OP_HOLD, 0, 8'h00, 0);
        tick();
        check_all("stall_e1", 8'hC0, 1, 0, 0);
        drive(0, 1, 1, OP_SHL, 5, 8'h55, 1);
        tick();
        check_all("stall_f1", 8'hC0, 1, 0, 0);
        tick();
        check_all("stall_f2", 8'hC0, 1, 0, 0);
        en = 1'b1;
        tick();
        check_all("stall_e2", 8'h60, 1, 0, 0);
        drive(1, 0, 0, OP_HOLD, 0, 8'h00, 0);
        tick();
        check_all("stall_e3", 8'h30, 0, 1, 0);
        en = 1'b0;
        tick();
        check_all("done_clears_en0", 8'h30, 0, 0, 0);

        // asynchronous reset mid-burst
        drive(1, 1, 0, OP_HOLD, 0, 8'hA5, 0);
        tick();
        drive(1, 0, 1, OP_ROL, 5, 8'h00, 0);
        tick();
        drive(1, 0, 0, OP_HOLD, 0, 8'h00, 0);
        tick();
        check_all("abort_e1", 8'h4B, 1, 0, 0);
        #2 rst = 1'b0;
        op = OP_ROL;
        #1;
        check_all("abort_now", 8'h00, 0, 0, 0);
        tick();
        check_all("abort_hold1", 8'h00, 0, 0, 0);
        tick();
        check_all("abort_hold2", 8'h00, 0, 0, 0);
        rst = 1'b1;
        op = OP_HOLD;
        tick();
        check_all("abort_release", 8'h00, 0, 0, 0);
        drive(1, 1, 0, OP_HOLD, 0, 8'h03, 0);
        tick();
        check_all("after_load", 8'h03, 0, 0, 0);
        drive(1, 0, 1, OP_SHL, 1, 8'h00, 1);
        tick();
        check_all("after_start", 8'h03, 1, 0, 0);
        drive(1, 0, 0, OP_HOLD, 0, 8'h00, 1);
        tick();
        check_all("after_e1", 8'h07, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
